mem_access_stage: RTL

- Pipeline MEM stage; sits between EX/MEM register and MEM/WB register.
- Executes loads/stores against a handshaked data-memory port: generates byte enables, store-data replication, load byte/halfword extraction and sign/zero extension.
- Stalls the pipeline while a transaction is outstanding; flags address misalignment and bus timeout.
- Its load_data output is the memory-data value captured by the MEM/WB register.

---
 rtl/mem_access_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline MEM stage between the EX/MEM and MEM/WB registers. Runs loads and
// stores against a req/ack data-memory port. It builds byte enables and
// lane-replicated store data, and extracts and extends load bytes/halfwords.
// The pipeline is stalled while an access is outstanding. Misaligned addresses
// and memory timeouts are reported as one-cycle pulses, with the faulting
// address held in bad_vaddr.
//
// Ports
//   clk, rset                   clock; asynchronous active-high reset
//   valid_in, mem_read,         EX/MEM instruction: live flag, load/store
//   mem_write, mem_size,        select, access size, extension mode,
//   load_signed, addr_in,       effective byte address and store data
//   wdata_in
//   flush                       suppresses the start of a new access
//   dm_req/we/be/addr/wdata     data-memory request, held stable while BUSY
//   dm_ack, dm_rdata            one-cycle completion with read data
//   stall_req                   freeze upstream stages and MEM/WB
//   load_data                   aligned/extended load result for MEM/WB
//   mem_done, bus_err           completion / timeout pulse (DONE cycle)
//   addr_err_load/store         misaligned access pulse (cycle after issue)
//   bad_vaddr                   address of the last fault
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 255   // max BUSY cycles without ack, 1..255
) (
   input  logic        clk,
   input  logic        rset,
   input  logic        valid_in,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        load_signed,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic        flush,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall_req,
   output logic [31:0] load_data,
   output logic        mem_done,
   output logic        addr_err_load,
   output logic        addr_err_store,
   output logic [31:0] bad_vaddr,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter value on the last BUSY cycle allowed before a timeout.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        load_q;      // latched op: 1 load, 0 store
   logic        signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  cnt_q;

   logic        misaligned_in;
   logic        access_in;    // live memory op offered in IDLE, not flushed
   logic        start_in;
   logic        fault_in;
   logic        busy;
   logic        timeout_hit;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rdata_fmt;

   // ---------------------------------------------------------------- issue
   // NOTE: every signal assigned in an always_comb gets a default first, so
   // no path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      misaligned_in = 1'b0;
      case (mem_size)
         2'b00:   misaligned_in = 1'b0;
         2'b01:   misaligned_in = addr_in[0];
         default: misaligned_in = (addr_in[1:0] != 2'b00);
      endcase
   end

   assign access_in = (state_q == IDLE) && valid_in && (mem_read || mem_write) && !flush;
   assign start_in  = access_in && !misaligned_in;
   assign fault_in  = access_in && misaligned_in;
   assign busy      = (state_q == BUSY);

   // An ack on the final allowed cycle wins over the timeout.
   assign timeout_hit = busy && !dm_ack && (cnt_q == CNT_LAST);

   // ------------------------------------------------------- memory request
   // Formatting comes only from latched values, so the request stays stable
   // for the whole BUSY period whatever the EX/MEM inputs do.
   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = '0;
      if (!load_q) begin
         case (size_q)
            2'b00: begin
               be_fmt    = 4'b0001 << addr_q[1:0];
               wdata_fmt = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               be_fmt    = addr_q[1] ? 4'b1100 : 4'b0011;
               wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: begin
               be_fmt    = 4'b1111;
               wdata_fmt = wdata_q;
            end
         endcase
      end
   end

   assign dm_req   = busy;
   assign dm_we    = busy && !load_q;
   assign dm_be    = busy ? be_fmt : 4'b0000;
   assign dm_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
   assign dm_wdata = busy ? wdata_fmt : '0;

   // Stall is combinational so the issuing cycle already freezes upstream;
   // it is forced low during reset so it falls together with dm_req.
   assign stall_req = !rset && (start_in || busy);

   // --------------------------------------------------------- load format
   always_comb begin
      rd_byte = dm_rdata[7:0];
      case (addr_q[1:0])
         2'b00: rd_byte = dm_rdata[7:0];
         2'b01: rd_byte = dm_rdata[15:8];
         2'b10: rd_byte = dm_rdata[23:16];
         2'b11: rd_byte = dm_rdata[31:24];
      endcase
      rd_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

      rdata_fmt = dm_rdata;
      case (size_q)
         2'b00:   rdata_fmt = {{24{signed_q & rd_byte[7]}}, rd_byte};
         2'b01:   rdata_fmt = {{16{signed_q & rd_half[15]}}, rd_half};
         default: rdata_fmt = dm_rdata;
      endcase
   end

   // ------------------------------------------------------------------ FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_in) state_d = BUSY;
         BUSY:    if (dm_ack || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;   // inputs here belong to the finished op
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         // NOTE: the latched request fields are reset as well, not only the
         // state, so nothing stale can reach the outputs after reset.
         state_q        <= IDLE;
         load_q         <= 1'b0;
         signed_q       <= 1'b0;
         size_q         <= 2'b00;
         addr_q         <= '0;
         wdata_q        <= '0;
         cnt_q          <= '0;
         load_data      <= '0;
         bad_vaddr      <= '0;
         mem_done       <= 1'b0;
         bus_err        <= 1'b0;
         addr_err_load  <= 1'b0;
         addr_err_store <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_done       <= 1'b0;
         bus_err        <= 1'b0;
         addr_err_load  <= 1'b0;
         addr_err_store <= 1'b0;

         if (start_in) begin
            load_q   <= mem_read;   // read+write together is a load
            signed_q <= load_signed;
            size_q   <= mem_size;
            addr_q   <= addr_in;
            wdata_q  <= wdata_in;
            cnt_q    <= '0;
         end

         if (fault_in) begin
            addr_err_load  <= mem_read;
            addr_err_store <= !mem_read;
            bad_vaddr      <= addr_in;
         end

         if (busy) begin
            if (dm_ack) begin
               mem_done <= 1'b1;
               if (load_q) load_data <= rdata_fmt;
            end else if (timeout_hit) begin
               bus_err   <= 1'b1;
               bad_vaddr <= addr_q;
               load_data <= '0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

endmodule
